// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory loader
package imem_pkg;

    typedef enum logic {
        IMEM_LOAD = 1'b0,
        IMEM_RUN  = 1'b1
    } imem_state_t;

    localparam int IMEM_WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_mem_if.sv
// rtl/imem_loader_mem_if.sv - loader stream and fetch port bundle
interface imem_loader_mem_if;

    logic        load_val;
    logic        load_rdy;
    logic [31:0] load_data;
    logic        load_last;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;

    modport master (
        output load_val, load_data, load_last, imemreq_val, imemreq_addr,
        input  load_rdy, imemresp_data
    );

    modport slave (
        input  load_val, load_data, load_last, imemreq_val, imemreq_addr,
        output load_rdy, imemresp_data
    );

endinterface

// File: rtl/imem_array.sv
// rtl/imem_array.sv - NWORDS x 32 storage, one sync write port, one async read port
module imem_array #(
    parameter int NWORDS = 256,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic          clk,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    // Contents deliberately survive reset so a program outlives a processor restart.
    logic [31:0] mem [NWORDS];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader_mem.sv
// rtl/imem_loader_mem.sv - loadable instruction memory with zero-latency fetch and reload
module imem_loader_mem
    import imem_pkg::*;
#(
    parameter int          NWORDS    = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          AW        = $clog2(NWORDS)
) (
    input  logic              clk,
    input  logic              rst,
    imem_loader_mem_if.slave  bus,
    input  logic              reload,
    output logic              proc_go,
    output logic [AW:0]       load_count,
    output logic              err
);

    imem_state_t   state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW:0]   count_q, count_d;
    logic          go_q, go_d;
    logic          err_q, err_d;

    logic [31:0]   offset;
    logic [31:0]   rdata;
    logic [AW-1:0] idx;
    logic          in_range;
    logic          aligned;
    logic          accept;
    logic          fetch_hit;

    // Modular subtraction lets a wrapped address fall out of range naturally.
    assign offset    = bus.imemreq_addr - BASE_ADDR;
    assign idx       = offset[AW+1:2];
    assign in_range  = offset < 32'(NWORDS * IMEM_WORD_BYTES);
    assign aligned   = (bus.imemreq_addr[1:0] == 2'b00);
    assign accept    = (state_q == IMEM_LOAD) && bus.load_val;
    assign fetch_hit = (state_q == IMEM_RUN) && bus.imemreq_val && in_range && aligned;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        err_d   = err_q;
        case (state_q)
            IMEM_LOAD: begin
                if (accept) begin
                    count_d = count_q + (AW+1)'(1);
                    // Capacity terminates the load so the pointer never wraps.
                    if (bus.load_last || (wptr_q == AW'(NWORDS - 1))) begin
                        state_d = IMEM_RUN;
                    end else begin
                        wptr_d = wptr_q + AW'(1);
                    end
                end
            end
            default: begin
                if (bus.imemreq_val && !(in_range && aligned)) begin
                    err_d = 1'b1;
                end
                if (reload) begin
                    state_d = IMEM_LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
        endcase
        go_d = (state_d == IMEM_RUN);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IMEM_LOAD;
            wptr_q  <= '0;
            count_q <= '0;
            go_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            go_q    <= go_d;
            err_q   <= err_d;
        end
    end

    imem_array #(
        .NWORDS (NWORDS),
        .AW     (AW)
    ) u_array (
        .clk   (clk),
        .wen   (accept),
        .waddr (wptr_q),
        .wdata (bus.load_data),
        .raddr (idx),
        .rdata (rdata)
    );

    assign bus.load_rdy      = (state_q == IMEM_LOAD);
    assign bus.imemresp_data = fetch_hit ? rdata : 32'h0;
    assign proc_go           = go_q;
    assign load_count        = count_q;
    assign err               = err_q;

endmodule

// File: tb/tb_imem_loader_mem.sv
// tb/tb_imem_loader_mem.sv - directed self-checking bench for imem_loader_mem
module tb_imem_loader_mem;

    localparam int NW = 16;
    localparam int AW = $clog2(NW);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          reload = 1'b0;
    logic          proc_go;
    logic [AW:0]   load_count;
    logic          err;

    int total = 0;
    int bad   = 0;
    logic [31:0] refm [NW];

    imem_loader_mem_if bus ();

    imem_loader_mem #(
        .NWORDS    (NW),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .reload     (reload),
        .proc_go    (proc_go),
        .load_count (load_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic last);
        bus.load_val  = 1'b1;
        bus.load_data = d;
        bus.load_last = last;
        @(negedge clk);
        bus.load_val  = 1'b0;
        bus.load_last = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.imemreq_val  = 1'b1;
        bus.imemreq_addr = addr;
        #1;
        chk(tag, bus.imemresp_data, exp);
    endtask

    initial begin
        int n;
        int cyc;
        logic v;
        logic [31:0] d;

        bus.load_val     = 1'b0;
        bus.load_data    = '0;
        bus.load_last    = 1'b0;
        bus.imemreq_val  = 1'b0;
        bus.imemreq_addr = '0;

        // Reset state
        #3;
        chk("rst_go",    32'(proc_go), 32'd0);
        chk("rst_rdy",   32'(bus.load_rdy), 32'd1);
        chk("rst_count", 32'(load_count), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // 3-word program terminated by load_last
        push(32'h0010_0093, 1'b0);
        push(32'h0020_0113, 1'b0);
        chk("t1_go_pre", 32'(proc_go), 32'd0);
        push(32'h0020_81B3, 1'b1);
        chk("t1_go",    32'(proc_go), 32'd1);
        chk("t1_count", 32'(load_count), 32'd3);
        chk("t1_rdy",   32'(bus.load_rdy), 32'd0);
        fetch("t1_f0", 32'h0, 32'h0010_0093);
        fetch("t1_f4", 32'h4, 32'h0020_0113);
        fetch("t1_f8", 32'h8, 32'h0020_81B3);
        bus.imemreq_val = 1'b0;
        #1;
        chk("t1_noval", bus.imemresp_data, 32'h0);
        @(negedge clk);

        // Misaligned then out-of-range fetch
        fetch("t3_mis", 32'h2, 32'h0);
        @(negedge clk);
        chk("t3_err", 32'(err), 32'd1);
        fetch("t3_oor", 32'(4 * NW), 32'h0);
        @(negedge clk);
        chk("t3_err_hold", 32'(err), 32'd1);

        // Reload with a same-cycle fetch that is still served
        reload = 1'b1;
        fetch("t4_f4", 32'h4, 32'h0020_0113);
        @(negedge clk);
        reload = 1'b0;
        bus.imemreq_val = 1'b0;
        chk("t4_go",    32'(proc_go), 32'd0);
        chk("t4_err",   32'(err), 32'd0);
        chk("t4_rdy",   32'(bus.load_rdy), 32'd1);
        chk("t4_count", 32'(load_count), 32'd0);
        fetch("t4_loadfetch", 32'h2, 32'h0);
        @(negedge clk);
        bus.imemreq_val = 1'b0;
        chk("t4_load_noerr", 32'(err), 32'd0);

        // Capacity terminates a load without load_last
        bus.load_val = 1'b1;
        for (int i = 0; i < NW; i++) begin
            bus.load_data = 32'hA000_0000 + 32'(i);
            if (i == NW - 1) chk("t2_rdy_last", 32'(bus.load_rdy), 32'd1);
            @(negedge clk);
        end
        chk("t2_go",    32'(proc_go), 32'd1);
        chk("t2_count", 32'(load_count), 32'(NW));
        chk("t2_rdy",   32'(bus.load_rdy), 32'd0);
        bus.load_data = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.load_val = 1'b0;
        chk("t2_count_hold", 32'(load_count), 32'(NW));
        fetch("t2_f0",   32'h0, 32'hA000_0000);
        fetch("t2_flast", 32'(4 * (NW - 1)), 32'hA000_0000 + 32'(NW - 1));
        bus.imemreq_val = 1'b0;

        // Async reset in RUN drops proc_go without a clock edge
        #2;
        rst = 1'b0;
        #1;
        chk("t5_go_async", 32'(proc_go), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        push(32'h0000_0011, 1'b0);
        push(32'h0000_0022, 1'b0);
        chk("t5_count2", 32'(load_count), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_count_abort", 32'(load_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        push(32'hCAFE_F00D, 1'b1);
        chk("t5_count1", 32'(load_count), 32'd1);
        fetch("t5_f0", 32'h0, 32'hCAFE_F00D);
        fetch("t5_f4", 32'h4, 32'h0000_0022);
        bus.imemreq_val = 1'b0;

        // Backpressured load with random valid
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 12 && cyc < 200) begin
            v = 1'($urandom_range(0, 1));
            d = $urandom;
            bus.load_val  = v;
            bus.load_data = d;
            bus.load_last = v && (n == 11);
            @(negedge clk);
            if (v) begin
                refm[n] = d;
                n++;
            end
            cyc++;
        end
        bus.load_val  = 1'b0;
        bus.load_last = 1'b0;
        chk("t6_done",  32'(n), 32'd12);
        chk("t6_count", 32'(load_count), 32'd12);
        chk("t6_go",    32'(proc_go), 32'd1);
        for (int i = 0; i < 12; i++) begin
            fetch($sformatf("t6_f%0d", i), 32'(4 * i), refm[i]);
        end
        fetch("t6_untouched", 32'h30, 32'hA000_000C);
        bus.imemreq_val = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
